// File: rtl/assist_pkg.sv
// -----------------------------------------------------------------------------
// assist_pkg
// Shared types and constants for the assist-mode controller:
//   state_t      controller state (IDLE, RAMP)
//   SETTING_W    width of the assist setting
//   SCALE_W      width of the torque scale
//   LIM_SETTING  highest setting allowed while the battery-low limit is active
//   scale_lut()  setting -> torque scale mapping
// -----------------------------------------------------------------------------
package assist_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    localparam int SETTING_W = 2;
    localparam int SCALE_W   = 3;

    localparam logic [SETTING_W-1:0] LIM_SETTING = 2'b01;

    function automatic logic [SCALE_W-1:0] scale_lut(input logic [SETTING_W-1:0] s);
        case (s)
            2'b00:   return 3'd0;
            2'b01:   return 3'd3;
            2'b10:   return 3'd5;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/assist_ramp_tick.sv
// -----------------------------------------------------------------------------
// assist_ramp_tick
// Free-running divider that paces ramp steps. While clr is high the counter
// is held at zero; otherwise it counts 0..RAMP_DIV-1 and wraps, raising tick
// for the single cycle in which it sits at the terminal count.
//   clk   in   system clock
//   rst   in   asynchronous, active-high reset
//   clr   in   hold counter at zero (controller idle)
//   tick  out  one-cycle pulse every RAMP_DIV counting cycles
// -----------------------------------------------------------------------------
module assist_ramp_tick #(
    parameter int RAMP_DIV = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int                CNT_W = $clog2(RAMP_DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(RAMP_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: flops are written with non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            // explicit wrap keeps non-power-of-two dividers inside 0..RAMP_DIV-1
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/assist_mode_ctrl.sv
// -----------------------------------------------------------------------------
// assist_mode_ctrl
// Owns the rider assist setting and ramps the downstream torque scale toward
// the setting's target one step per RAMP_DIV cycles. Arbitrates between the
// push-button release pulse and a remote command channel, and enforces the
// battery-low cap.
//   clk           in   system clock
//   rst           in   asynchronous, active-high reset
//   btn_rel       in   one-cycle pulse per button release (setting + 1)
//   cmd_vld       in   remote command valid
//   cmd_setting   in   requested setting
//   cmd_rdy       out  command accepted when cmd_vld & cmd_rdy
//   lim_en        in   battery-low; caps setting at LIM_SETTING
//   setting       out  committed assist setting
//   target_scale  out  scale_lut(setting)
//   scale         out  ramped scale to the datapath
//   busy          out  high while ramping
//   chg_pulse     out  one-cycle pulse when setting changes value
// -----------------------------------------------------------------------------
module assist_mode_ctrl
    import assist_pkg::*;
#(
    parameter int                   RAMP_DIV    = 1024,
    parameter logic [SETTING_W-1:0] RST_SETTING = 2'b10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_rel,
    input  logic                 cmd_vld,
    input  logic [SETTING_W-1:0] cmd_setting,
    output logic                 cmd_rdy,
    input  logic                 lim_en,
    output logic [SETTING_W-1:0] setting,
    output logic [SCALE_W-1:0]   target_scale,
    output logic [SCALE_W-1:0]   scale,
    output logic                 busy,
    output logic                 chg_pulse
);

    state_t                 state;
    logic                   pend;
    logic                   tick;

    logic                   clamp;
    logic [SETTING_W-1:0]   inc_setting;
    logic [SETTING_W-1:0]   cmd_eff;
    logic [SETTING_W-1:0]   nxt_setting;
    logic [SCALE_W-1:0]     nxt_target;
    logic [SCALE_W-1:0]     nxt_scale;
    logic                   nxt_pend;
    logic                   nxt_ramp;

    assist_ramp_tick #(
        .RAMP_DIV (RAMP_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == IDLE),
        .tick (tick)
    );

    // Under the limit the button toggles between the two allowed settings.
    assign inc_setting = lim_en ? ((setting == 2'b00) ? LIM_SETTING : 2'b00)
                                : setting + 2'd1;
    assign cmd_eff     = (lim_en && cmd_setting > LIM_SETTING) ? LIM_SETTING : cmd_setting;
    assign clamp       = lim_en && (setting > LIM_SETTING);

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        nxt_setting = setting;
        nxt_pend    = pend;
        nxt_scale   = scale;

        if (state == IDLE) begin
            // clamp > command > pending press > fresh press; a losing press
            // is parked in pend, an existing pend is kept.
            if (clamp) begin
                nxt_setting = LIM_SETTING;
                if (btn_rel) nxt_pend = 1'b1;
            end else if (cmd_vld) begin
                nxt_setting = cmd_eff;
                if (btn_rel) nxt_pend = 1'b1;
            end else if (pend) begin
                nxt_setting = inc_setting;
                nxt_pend    = btn_rel;
            end else if (btn_rel) begin
                nxt_setting = inc_setting;
            end
        end else begin
            if (btn_rel) nxt_pend = 1'b1;
            // battery-low retargets the ramp without restarting the divider
            if (clamp) nxt_setting = LIM_SETTING;
        end

        nxt_target = scale_lut(nxt_setting);

        if (state == RAMP && tick) begin
            if (scale < nxt_target) begin
                nxt_scale = scale + 3'd1;
            end else if (scale > nxt_target) begin
                nxt_scale = scale - 3'd1;
            end
        end

        // In IDLE scale already equals the old target, so this is exactly
        // "new target differs"; in RAMP it ends the ramp on arrival.
        nxt_ramp = (nxt_scale != nxt_target);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            setting   <= RST_SETTING;
            scale     <= scale_lut(RST_SETTING);
            pend      <= 1'b0;
            busy      <= 1'b0;
            chg_pulse <= 1'b0;
        end else begin
            state     <= nxt_ramp ? RAMP : IDLE;
            setting   <= nxt_setting;
            scale     <= nxt_scale;
            pend      <= nxt_pend;
            busy      <= nxt_ramp;
            chg_pulse <= (nxt_setting != setting);
        end
    end

    assign target_scale = scale_lut(setting);
    assign cmd_rdy      = (state == IDLE) && !rst;

endmodule

// File: tb/tb_assist_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_assist_mode_ctrl
// Directed scenarios followed by randomized traffic, all compared every cycle
// against a behavioural model of the assist controller.
// -----------------------------------------------------------------------------
module tb_assist_mode_ctrl;

    localparam int RAMP_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_rel = 1'b0;
    logic       cmd_vld = 1'b0;
    logic [1:0] cmd_setting = 2'b00;
    logic       lim_en = 1'b0;
    logic       cmd_rdy;
    logic [1:0] setting;
    logic [2:0] target_scale;
    logic [2:0] scale;
    logic       busy;
    logic       chg_pulse;

    int checks = 0;
    int errors = 0;

    assist_mode_ctrl #(
        .RAMP_DIV    (RAMP_DIV),
        .RST_SETTING (2'b10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_rel      (btn_rel),
        .cmd_vld      (cmd_vld),
        .cmd_setting  (cmd_setting),
        .cmd_rdy      (cmd_rdy),
        .lim_en       (lim_en),
        .setting      (setting),
        .target_scale (target_scale),
        .scale        (scale),
        .busy         (busy),
        .chg_pulse    (chg_pulse)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int lut [4] = '{0, 3, 5, 7};
    int m_set, m_scl, m_left;
    bit m_ramp, m_pend, m_chg;

    function automatic int next_up(input int s, input bit l);
        if (l) return (s == 0) ? 1 : 0;
        return (s + 1) % 4;
    endfunction

    task automatic model_reset();
        m_set  = 2;
        m_scl  = lut[2];
        m_ramp = 0;
        m_pend = 0;
        m_chg  = 0;
        m_left = 0;
    endtask

    // Predicts the state after one clock edge with the given inputs.
    task automatic model_step(input bit b, input bit v, input int c, input bit l);
        int ns;
        if (!m_ramp) begin
            ns = m_set;
            if (l && m_set > 1) begin
                ns = 1;
                if (b) m_pend = 1;
            end else if (v) begin
                ns = (l && c > 1) ? 1 : c;
                if (b) m_pend = 1;
            end else if (m_pend) begin
                ns = next_up(m_set, l);
                m_pend = b;
            end else if (b) begin
                ns = next_up(m_set, l);
            end
            m_chg = (ns != m_set);
            m_set = ns;
            if (lut[m_set] != m_scl) begin
                m_ramp = 1;
                m_left = RAMP_DIV;
            end
        end else begin
            m_chg = 0;
            if (b) m_pend = 1;
            if (l && m_set > 1) begin
                m_set = 1;
                m_chg = 1;
            end
            m_left--;
            if (m_left == 0) begin
                if (lut[m_set] > m_scl) m_scl++;
                else if (lut[m_set] < m_scl) m_scl--;
                m_left = RAMP_DIV;
            end
            if (m_scl == lut[m_set]) m_ramp = 0;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("setting",      8'(setting),      8'(m_set));
        check("scale",        8'(scale),        8'(m_scl));
        check("target_scale", 8'(target_scale), 8'(lut[m_set]));
        check("busy",         8'(busy),         8'(m_ramp));
        check("chg_pulse",    8'(chg_pulse),    8'(m_chg));
        check("cmd_rdy",      8'(cmd_rdy),      rst ? 8'd0 : 8'(!m_ramp));
    endtask

    // Check the current outputs, then drive inputs for the next edge.
    task automatic cycle(input bit b, input bit v, input logic [1:0] c, input bit l);
        @(negedge clk);
        check_all();
        btn_rel     = b;
        cmd_vld     = v;
        cmd_setting = c;
        lim_en      = l;
        model_step(b, v, int'(c), l);
    endtask

    task automatic idle(input int n, input bit l);
        for (int i = 0; i < n; i++) cycle(0, 0, 2'b00, l);
    endtask

    // Called at a negedge: asserts rst asynchronously and releases it one cycle later.
    task automatic do_reset();
        check_all();
        rst = 1'b1;
        btn_rel = 1'b0; cmd_vld = 1'b0; cmd_setting = 2'b00; lim_en = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        model_step(0, 0, 0, 0);
    endtask

    bit lim_r;

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;
        model_step(0, 0, 0, 0);

        // quiet after reset
        idle(100, 0);
        check("quiet_setting", 8'(setting), 8'd2);
        check("quiet_scale",   8'(scale),   8'd5);

        // button 10 -> 11, ramp 5 -> 7
        cycle(1, 0, 2'b00, 0);
        idle(12, 0);
        check("btn_setting", 8'(setting), 8'd3);
        check("btn_scale",   8'(scale),   8'd7);

        // command 00, button mid-ramp becomes pending -> 01
        cycle(0, 1, 2'b00, 0);
        idle(6, 0);
        cycle(1, 0, 2'b00, 0);
        idle(60, 0);
        check("pend_setting", 8'(setting), 8'd1);
        check("pend_scale",   8'(scale),   8'd3);

        // button and command in the same idle cycle
        cycle(1, 1, 2'b11, 0);
        idle(60, 0);
        check("race_setting", 8'(setting), 8'd0);
        check("race_scale",   8'(scale),   8'd0);

        // battery-low mid-ramp, then limited command and button
        cycle(0, 1, 2'b11, 0);
        idle(6, 0);
        idle(40, 1);
        check("lim_setting", 8'(setting), 8'd1);
        check("lim_scale",   8'(scale),   8'd3);
        cycle(0, 1, 2'b10, 1);
        idle(5, 1);
        check("lim_cmd_setting", 8'(setting), 8'd1);
        cycle(1, 0, 2'b00, 1);
        idle(20, 1);
        check("lim_btn_setting", 8'(setting), 8'd0);
        idle(2, 0);

        // reset mid-ramp at scale 6
        @(negedge clk);
        do_reset();
        cycle(0, 1, 2'b11, 0);
        idle(4, 0);
        @(negedge clk);
        check("pre_rst_scale", 8'(scale), 8'd6);
        model_step(0, 0, 0, 0);
        @(negedge clk);
        do_reset();
        check("rst_scale",   8'(scale),   8'd5);
        check("rst_setting", 8'(setting), 8'd2);
        check("rst_busy",    8'(busy),    8'd0);

        // command held while busy is taken only once idle
        cycle(0, 1, 2'b11, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 2'b00, 0);
        check("hold_setting", 8'(setting), 8'd3);
        for (int i = 0; i < 9; i++) cycle(0, 1, 2'b00, 0);
        idle(40, 0);
        check("hold_final_setting", 8'(setting), 8'd0);
        check("hold_final_scale",   8'(scale),   8'd0);

        // randomized traffic
        lim_r = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) lim_r = !lim_r;
            if ($urandom_range(0, 599) == 0) begin
                @(negedge clk);
                do_reset();
                lim_r = 0;
            end else begin
                cycle($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                      2'($urandom_range(0, 3)), lim_r);
            end
        end
        idle(40, 0);
        @(negedge clk);
        check_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/assist_mode_ctrl.md
# assist_mode_ctrl

Assist-mode controller that owns the rider assist setting and sequences the torque scale applied downstream. It arbitrates setting changes between the debounced push-button release pulse and a remote command channel, enforces a battery-low cap, and ramps the scale output one step at a time toward the target instead of jumping. It sits between the push-button release detector and the torque/assist datapath.

## Interface

- RAMP_DIV, 1024, cycles between consecutive scale steps during a ramp (≥2)
- RST_SETTING, 2'b10, setting loaded on reset

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- btn_rel  in  1  single-cycle pulse per button release; requests setting+1
- cmd_vld  in  1  remote command valid
- cmd_setting  in  2  requested setting
- cmd_rdy  out  1  command accepted when cmd_vld & cmd_rdy
- lim_en  in  1  battery-low; caps setting at 2'b01 while high
- setting  out  2  committed assist setting
- target_scale  out  3  LUT(setting)
- scale  out  3  ramped scale to datapath
- busy  out  1  high in RAMP
- chg_pulse  out  1  one-cycle pulse when setting changes value

## Operation

- LUT: 00→0, 01→3, 10→5, 11→7.
- Reset: setting=RST_SETTING, scale=target_scale=LUT(RST_SETTING)=5, state IDLE, busy=0, cmd_rdy=1, chg_pulse=0, pend=0, divider=0.
- States: IDLE, RAMP. cmd_rdy = (state==IDLE) & !rst.
- Button: btn_rel in IDLE → setting+1 (mod 4). btn_rel in RAMP → pend=1 (one deep; further pulses while pend=1 dropped). pend consumed on first IDLE cycle.
- Limit: while lim_en=1, allowed set {00,01}; button increment 01→00, 00→01; cmd_setting>01 clamped to 01. lim_en rising with setting>01 → setting forced to 01 (any state; if RAMP, target retargets, ramp continues from current scale).
- Same-cycle priority in IDLE: lim clamp > cmd accept > pend > btn_rel; losers: btn_rel→pend=1, pend retained.
- Commit: setting updates; if new≠old, chg_pulse=1. If LUT(new)≠scale → RAMP, divider cleared; else stay IDLE.
- RAMP: divider counts 0..RAMP_DIV-1; at terminal count scale steps ±1 toward target_scale. When scale==target_scale after a step → IDLE.

## Timing

- Command accepted at edge N (cmd_vld&cmd_rdy) → setting, target_scale, chg_pulse valid after edge N; busy after edge N.
- First scale step RAMP_DIV cycles after commit; full ramp |Δ|×RAMP_DIV cycles; IDLE (cmd_rdy=1) the cycle after final step.
- Pending button applied at the edge after return to IDLE.
- cmd_vld held with cmd_rdy=0: no effect, no loss; requester holds.
- rst mid-ramp: all outputs return to reset values immediately (async), no partial step.
- Divider width $clog2(RAMP_DIV); no overflow beyond RAMP_DIV-1.

## Structure

- Package assist_pkg: state enum (IDLE, RAMP), SETTING_W=2, SCALE_W=3, LIM_SETTING=2'b01, function scale_lut(setting).
- Sub-module assist_ramp_tick: divider counter with clear input and tick output; controller FSM, arbitration, pend and clamp logic in top.

## Test plan

- Reset release → setting=10, scale=5, busy=0, cmd_rdy=1; no btn/cmd for 100 cycles → outputs unchanged.
- RAMP_DIV=4, btn_rel from 10 → setting=11, chg_pulse one cycle, scale 5→6→7 at 4-cycle intervals, busy low after step to 7.
- cmd_setting=00 from 10 → scale 5→4→3→2→1→0 over 20 cycles; btn_rel mid-ramp → pend; after IDLE setting=01, ramp 0→3.
- btn_rel and cmd_vld(11) same IDLE cycle → setting=11; pend applied after ramp → setting=00, ramp to 0.
- lim_en rises at setting=11 mid-ramp → setting=01, target 3, scale ramps toward 3; cmd_setting=10 under lim → setting 01; btn_rel → 00.
- rst asserted mid-ramp (scale=6) → scale=5, setting=10, busy=0 immediately; cmd_vld held through RAMP accepted only once cmd_rdy=1.
